// File: rtl/fpu_sequencer_if.sv
// fpu_sequencer_if: start/operand handshake, core operand/result buses and completion status of the FPU sequencer.
interface fpu_sequencer_if;
    logic        fpu_en_pulse;
    logic [3:0]  fpu_ctrl;
    logic [31:0] fpu_rs1;
    logic [31:0] fpu_rs2;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] fadd_y;
    logic [31:0] fmul_y;
    logic [31:0] fdiv_y;
    logic [31:0] fsqrt_y;
    logic [31:0] fcvtws_y;
    logic [31:0] fcvtsw_y;
    logic [31:0] fpu_result;
    logic        fpu_valid;
    logic        busy;
    logic        err;
    modport master (
        output fpu_en_pulse, fpu_ctrl, fpu_rs1, fpu_rs2,
        output fadd_y, fmul_y, fdiv_y, fsqrt_y, fcvtws_y, fcvtsw_y,
        input  op_a, op_b, fpu_result, fpu_valid, busy, err
    );
    modport slave (
        input  fpu_en_pulse, fpu_ctrl, fpu_rs1, fpu_rs2,
        input  fadd_y, fmul_y, fdiv_y, fsqrt_y, fcvtws_y, fcvtsw_y,
        output op_a, op_b, fpu_result, fpu_valid, busy, err
    );
endinterface

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: multi-cycle FPU controller; sequences fixed-latency external cores and evaluates sign-injection/compare ops locally.
module fpu_sequencer #(
    parameter int unsigned FADD_LAT  = 2,
    parameter int unsigned FMUL_LAT  = 2,
    parameter int unsigned FDIV_LAT  = 10,
    parameter int unsigned FSQRT_LAT = 8,
    parameter int unsigned FCVT_LAT  = 2
) (
    input logic        clk,
    input logic        rst,
    fpu_sequencer_if.slave f
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state, state_nx;
    logic [3:0]  op;
    logic [4:0]  cnt;
    logic [4:0]  lat_m1;
    logic        start;
    logic [31:0] opb_nx;
    logic [31:0] res_sel;
    logic        a_nan, b_nan, any_nan, both_zero, eq, lt;
    logic [31:0] a, b;

    assign start = f.fpu_en_pulse && state != RUN;

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = cnt == 5'd0 ? DONE : RUN;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        f.busy      = state == RUN;
        f.fpu_valid = state == DONE;
    end

    always_comb begin
        lat_m1 = f.fpu_ctrl <= 4'd1 ? 5'(FADD_LAT - 1) :
                 f.fpu_ctrl == 4'd2 ? 5'(FMUL_LAT - 1) :
                 f.fpu_ctrl == 4'd3 ? 5'(FDIV_LAT - 1) :
                 f.fpu_ctrl == 4'd4 ? 5'(FSQRT_LAT - 1) :
                 f.fpu_ctrl <= 4'd6 ? 5'(FCVT_LAT - 1) : 5'd0;
        opb_nx = f.fpu_ctrl == 4'd1 ? {~f.fpu_rs2[31], f.fpu_rs2[30:0]} :
                 (f.fpu_ctrl >= 4'd4 && f.fpu_ctrl <= 4'd6) ? 32'd0 : f.fpu_rs2;
    end

    // Sign-magnitude compare: -0 == +0, negative pairs reverse the magnitude order, NaN is unordered.
    always_comb begin
        a         = f.op_a;
        b         = f.op_b;
        a_nan     = a[30:23] == 8'hFF && a[22:0] != 23'd0;
        b_nan     = b[30:23] == 8'hFF && b[22:0] != 23'd0;
        any_nan   = a_nan || b_nan;
        both_zero = (a[30:0] | b[30:0]) == 31'd0;
        eq        = !any_nan && (a == b || both_zero);
        lt        = !any_nan && !both_zero &&
                    (a[31] != b[31] ? a[31] : a[31] ? a[30:0] > b[30:0] : a[30:0] < b[30:0]);
        res_sel   = 32'd0;
        case (op)
            4'd0, 4'd1: res_sel = f.fadd_y;
            4'd2:       res_sel = f.fmul_y;
            4'd3:       res_sel = f.fdiv_y;
            4'd4:       res_sel = f.fsqrt_y;
            4'd5:       res_sel = f.fcvtws_y;
            4'd6:       res_sel = f.fcvtsw_y;
            4'd7:       res_sel = {b[31], a[30:0]};
            4'd8:       res_sel = {~b[31], a[30:0]};
            4'd9:       res_sel = {a[31] ^ b[31], a[30:0]};
            4'd10:      res_sel = {31'd0, eq};
            4'd11:      res_sel = {31'd0, lt};
            4'd12:      res_sel = {31'd0, lt || eq};
            default:    res_sel = 32'd0;
        endcase
    end

    // Core outputs are only captured on the counter-zero cycle of RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            op           <= 4'd0;
            cnt          <= 5'd0;
            f.op_a       <= 32'd0;
            f.op_b       <= 32'd0;
            f.fpu_result <= 32'd0;
            f.err        <= 1'b0;
        end else begin
            f.err <= f.fpu_en_pulse && (state == RUN || f.fpu_ctrl >= 4'd13);
            if (start) begin
                op     <= f.fpu_ctrl;
                f.op_a <= f.fpu_rs1;
                f.op_b <= opb_nx;
                cnt    <= lat_m1;
            end else if (state == RUN) begin
                if (cnt != 5'd0) cnt <= cnt - 5'd1;
                else             f.fpu_result <= res_sel;
            end
        end
    end
endmodule
